// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, flag bit indices and FSM states shared by alu_seq_core and its multiplier.
package alu_seq_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam int FLAG_COMPARE  = 0;
    localparam int FLAG_EQUAL    = 1;
    localparam int FLAG_CARRY    = 2;
    localparam int FLAG_OVERFLOW = 3;
    localparam int FLAG_ZERO     = 4;
    localparam int FLAG_ERR      = 5;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    function automatic logic [5:0] pack_flags(input logic err, zero, ovf, carry, eq, cmp);
        logic [5:0] f;
        f                = '0;
        f[FLAG_ERR]      = err;
        f[FLAG_ZERO]     = zero;
        f[FLAG_OVERFLOW] = ovf;
        f[FLAG_CARRY]    = carry;
        f[FLAG_EQUAL]    = eq;
        f[FLAG_COMPARE]  = cmp;
        return f;
    endfunction
endpackage

// File: rtl/alu_seq_mul_iter.sv
// alu_seq_mul_iter: shift-add multiplier, one multiplier bit per cycle; done pulses with the final product.
module alu_seq_mul_iter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    logic               run;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    // product is the accumulator after the current step, so the last step is visible with done
    assign product = mplier[0] ? acc + mcand : acc;
    assign done    = run && cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (run) begin
            run    <= !done;
            cnt    <= done ? '0 : cnt + CW'(1);
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked ALU with registered result and flags.
// Define ALU_SEQ_MUL_EN to make opcode 8 an iterative WIDTH-cycle multiply; otherwise it is illegal.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [5:0]       out_flags,
    output logic             busy
);
    state_t           state;
    logic             accept, is_mul, mul_done;
    logic             cmp_c, eq_c, carry_c, ovf_c, err_c;
    logic [WIDTH:0]   sum_add, sum_sub;
    logic [WIDTH-1:0] res_c, mul_res;
    logic [5:0]       flags_c, mul_flags;

    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign busy      = state == ST_BUSY;
    assign accept    = in_valid && in_ready;
    assign cmp_c     = $signed(in_a) < $signed(in_b);
    assign eq_c      = in_a == in_b;
    assign sum_add   = {1'b0, in_a} + {1'b0, in_b};
    assign sum_sub   = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
    assign flags_c   = pack_flags(err_c, res_c == '0, ovf_c, carry_c, eq_c, cmp_c);

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        err_c   = 1'b0;
        case (in_op)
            OP_ADD: begin
                res_c   = sum_add[WIDTH-1:0];
                carry_c = sum_add[WIDTH];
                ovf_c   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_add[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c   = sum_sub[WIDTH-1:0];
                carry_c = sum_sub[WIDTH];
                ovf_c   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sum_sub[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_NOT:  res_c = ~in_a;
            OP_AND:  res_c = in_a & in_b;
            OP_OR:   res_c = in_a | in_b;
            OP_XOR:  res_c = in_a ^ in_b;
            OP_CMP:  res_c = WIDTH'(cmp_c);
            OP_EQ:   res_c = WIDTH'(eq_c);
            default: err_c = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] mul_prod;
    logic               cmp_q, eq_q;
    assign is_mul    = in_op == OP_MUL;
    assign mul_res   = mul_prod[WIDTH-1:0];
    assign mul_flags = pack_flags(1'b0, mul_res == '0, 1'b0, |mul_prod[2*WIDTH-1:WIDTH], eq_q, cmp_q);
    alu_seq_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_prod)
    );
    // compare/equal describe the accepted operands, which are gone by the time MUL finishes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_q <= 1'b0;
            eq_q  <= 1'b0;
        end else if (accept) begin
            cmp_q <= cmp_c;
            eq_q  <= eq_c;
        end
    end
`else
    assign is_mul    = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_res   = '0;
    assign mul_flags = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    state <= is_mul ? ST_BUSY : ST_DONE;
                    if (!is_mul) begin
                        out_result <= res_c;
                        out_flags  <= flags_c;
                    end
                end
                ST_BUSY: if (mul_done) begin
                    state      <= ST_DONE;
                    out_result <= mul_res;
                    out_flags  <= mul_flags;
                end
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: table-driven check of single-cycle ops plus handshake, reset and MUL sequences (WIDTH=4).
module tb_alu_seq_core;
    import alu_seq_pkg::*;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   in_op = '0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] out_result;
    logic [5:0]   out_flags;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [5:0]   flags;
    } vec_t;
    vec_t vq[$];

    alu_seq_core #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // present one op at a negedge; returns at the negedge after its accept edge
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        chk("ready_before_issue", in_ready, 1);
        in_op = op;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_drain", {out_valid, in_ready}, 2'b01);
    endtask

    task automatic mul_wait(input logic [W-1:0] res, input logic [5:0] flags);
        for (int i = 0; i < W; i++) begin
            chk("mul_busy", {busy, out_valid}, 2'b10);
            @(negedge clk);
        end
        chk("mul_valid", {busy, out_valid}, 2'b01);
        chk("mul_result", out_result, res);
        chk("mul_flags", out_flags, flags);
        drain();
    endtask

    initial begin
        // flags = {err, zero, overflow, carry, equal, compare}
        vq.push_back('{OP_ADD, 4'h7, 4'h1, 4'h8, 6'b001000});
        vq.push_back('{OP_SUB, 4'h3, 4'h5, 4'hE, 6'b000001});
        vq.push_back('{OP_EQ,  4'hA, 4'hA, 4'h1, 6'b000010});
        vq.push_back('{OP_ADD, 4'hF, 4'h1, 4'h0, 6'b010101});
        vq.push_back('{OP_SUB, 4'h8, 4'h1, 4'h7, 6'b001101});
        vq.push_back('{OP_SUB, 4'h5, 4'h5, 4'h0, 6'b010110});
        vq.push_back('{OP_NOT, 4'h5, 4'h5, 4'hA, 6'b000010});
        vq.push_back('{OP_AND, 4'hC, 4'hA, 4'h8, 6'b000000});
        vq.push_back('{OP_OR,  4'hC, 4'h3, 4'hF, 6'b000001});
        vq.push_back('{OP_XOR, 4'h6, 4'h6, 4'h0, 6'b010010});
        vq.push_back('{OP_CMP, 4'h2, 4'hE, 4'h0, 6'b010000});
        vq.push_back('{OP_CMP, 4'hE, 4'h2, 4'h1, 6'b000001});
        vq.push_back('{4'hC,   4'h3, 4'h4, 4'h0, 6'b110001});
`ifndef ALU_SEQ_MUL_EN
        vq.push_back('{OP_MUL, 4'h3, 4'h4, 4'h0, 6'b110001});
`endif

        repeat (2) @(negedge clk);
        chk("reset_handshake", {in_ready, out_valid, busy}, 3'b100);
        chk("reset_result", out_result, 0);
        chk("reset_flags", out_flags, 0);
        rst = 1'b0;

        foreach (vq[i]) begin
            issue(vq[i].op, vq[i].a, vq[i].b);
            chk($sformatf("vec%0d_valid", i), {out_valid, in_ready, busy}, 3'b100);
            chk($sformatf("vec%0d_result", i), out_result, vq[i].res);
            chk($sformatf("vec%0d_flags", i), out_flags, vq[i].flags);
            drain();
        end

        // backpressure: result held, new request stalls until the cycle after the drain
        issue(OP_ADD, 4'h1, 4'h2);
        in_op = OP_AND;
        in_a = 4'hF;
        in_b = 4'h5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {out_valid, in_ready}, 2'b10);
            chk("bp_result", out_result, 4'h3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_return_idle", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_result", out_result, 4'h5);
        drain();

`ifdef ALU_SEQ_MUL_EN
        // 7*6 = 0x2A: low nibble A, upper nibble nonzero -> carry
        issue(OP_MUL, 4'h7, 4'h6);
        mul_wait(4'hA, 6'b000100);
        issue(OP_MUL, 4'h7, 4'h6);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mul_abort_handshake", {in_ready, out_valid, busy}, 3'b100);
        chk("mul_abort_result", out_result, 0);
        chk("mul_abort_flags", out_flags, 0);
        @(negedge clk);
        rst = 1'b0;
        issue(OP_MUL, 4'h3, 4'h5);
        mul_wait(4'hF, 6'b000001);
`endif

        issue(OP_ADD, 4'h2, 4'h3);
        chk("done_before_rst", out_result, 4'h5);
        rst = 1'b1;
        #1;
        chk("done_rst_handshake", {in_ready, out_valid, busy}, 3'b100);
        chk("done_rst_result", out_result, 0);
        chk("done_rst_flags", out_flags, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
